// File: rtl/sequence_decoder_if.sv
// sequence_decoder_if
//   Groups the load/string input and the symbol valid/ready handshake of
//   sequence_decoder, plus its status outputs. Signal prefixes are written
//   from the decoder's point of view (i_ = into the decoder, o_ = out of it).
//
//   i_load       start a decode of i_string_in (accepted only when idle)
//   i_string_in  64-bit encoded input string
//   i_sym_ready  consumer accepts o_sym this cycle
//   o_sym_valid  o_sym holds a decoded symbol
//   o_sym        1=toggle 2=push 3=mic 4=mouse, 0 when not valid
//   o_sym_last   current symbol is the final one of the string
//   o_busy       decoder is not idle
//   o_done       one-cycle pulse on successful completion
//   o_error      malformed string, held until next accepted load or reset
//   o_sym_count  symbols handed off since the last accepted load
//
//   master : the side that loads strings and consumes symbols
//   slave  : the decoder itself
interface sequence_decoder_if;
  logic        i_load;
  logic [63:0] i_string_in;
  logic        i_sym_ready;
  logic        o_sym_valid;
  logic [2:0]  o_sym;
  logic        o_sym_last;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [5:0]  o_sym_count;

  modport master (
    output i_load, i_string_in, i_sym_ready,
    input  o_sym_valid, o_sym, o_sym_last, o_busy, o_done, o_error, o_sym_count
  );

  modport slave (
    input  i_load, i_string_in, i_sym_ready,
    output o_sym_valid, o_sym, o_sym_last, o_busy, o_done, o_error, o_sym_count
  );
endinterface

// File: rtl/sequence_decoder.sv
// sequence_decoder
//   Decodes a 64-bit encoded input string into its ordered symbols, oldest
//   (most significant) codeword first, one symbol per valid/ready handshake.
//   Codewords are runs of ones closed by a zero: 10=toggle, 110=push,
//   1110=mic, 11110=mouse.
//
//   clock  system clock, all state changes on posedge
//   reset  synchronous, active-low; returns to IDLE with everything cleared
//   bus    sequence_decoder_if.slave (load/string in, symbol handshake out,
//          busy/done/error/sym_count status)
module sequence_decoder (
  input  logic                      clock,
  input  logic                      reset,
  sequence_decoder_if.slave         bus
);

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    COUNT,
    EMIT,
    DONE,
    ERR
  } state_t;

  state_t      r_state;
  logic [63:0] r_sh;
  logic [2:0]  r_ones;
  logic [6:0]  r_bitCnt;
  logic        r_symValid;
  logic [2:0]  r_sym;
  logic        r_symLast;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [5:0]  r_symCount;

  logic        w_shEmpty;
  logic        w_exhausted;
  logic        w_restEmpty;

  // The zero fill makes a consumed-out register look like a trailing zero,
  // so a count of consumed bits tells a real terminator (e.g. bit 0 of
  // 64'h2) apart from running off the end of the string after a one.
  assign w_shEmpty   = (r_sh == 64'd0);
  assign w_exhausted = (r_bitCnt == 7'd64);
  assign w_restEmpty = (r_sh[62:0] == 63'd0);

  // Single FSM with the shift datapath and all outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_sh       <= 64'd0;
      r_ones     <= 3'd0;
      r_bitCnt   <= 7'd0;
      r_symValid <= 1'b0;
      r_sym      <= 3'd0;
      r_symLast  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_symCount <= 6'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_load) begin
            r_sh       <= bus.i_string_in;
            r_ones     <= 3'd0;
            r_bitCnt   <= 7'd0;
            r_symCount <= 6'd0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SKIP;
          end
        end
        SKIP: begin
          if (w_shEmpty) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (!r_sh[63]) begin
            r_sh     <= {r_sh[62:0], 1'b0};
            r_bitCnt <= r_bitCnt + 7'd1;
          end else begin
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (r_sh[63]) begin
            // A fifth one cannot belong to any codeword.
            if (r_ones == 3'd4) begin
              r_state <= ERR;
            end else begin
              r_sh     <= {r_sh[62:0], 1'b0};
              r_bitCnt <= r_bitCnt + 7'd1;
              r_ones   <= r_ones + 3'd1;
            end
          end else if ((r_ones == 3'd0) || w_exhausted) begin
            r_state <= ERR;
          end else begin
            r_sh       <= {r_sh[62:0], 1'b0};
            r_bitCnt   <= r_bitCnt + 7'd1;
            r_sym      <= r_ones;
            r_symValid <= 1'b1;
            r_symLast  <= w_restEmpty;
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (bus.i_sym_ready) begin
            r_symCount <= r_symCount + 6'd1;
            r_ones     <= 3'd0;
            r_symValid <= 1'b0;
            r_sym      <= 3'd0;
            r_symLast  <= 1'b0;
            if (r_symLast) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= COUNT;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        ERR: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_sym_valid = r_symValid;
  assign bus.o_sym       = r_sym;
  assign bus.o_sym_last  = r_symLast;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_error     = r_error;
  assign bus.o_sym_count = r_symCount;

endmodule
